// File: rtl/uart_fifo_port_pkg.sv
// Shared definitions for the UART bus port: register map, status/control bit
// positions, engine state encodings and the baud-divisor floor.
package uart_fifo_port_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_TX_BUSY   = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_RX_FULL   = 4;
  localparam int STAT_RX_OVR    = 5;
  localparam int STAT_FRAME_ERR = 6;
  localparam int STAT_TX_OVF    = 7;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_RX_IE = 3;
  localparam int CTRL_TX_IE = 4;

  localparam logic [4:0]  CTRL_RESET = 5'b00011;
  localparam logic [15:0] DIV_MIN    = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with one-cycle push/pop, full/empty flags and fill level.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_port.sv
// Bus-slave full-duplex UART with TX/RX byte FIFOs, runtime baud divisor,
// internal loopback, sticky error flags and a registered level interrupt.
module uart_fifo_port
  import uart_fifo_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3FFF_FFF0,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd54,
  parameter int          STOP_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  inout  wire  [31:0] data,
  input  logic        request,
  input  logic        r_w,
  output logic        ready_out,
  input  logic        RxD,
  output logic        TxD,
  output logic        irq
);

  localparam int   TX_AW     = $clog2(TX_DEPTH);
  localparam int   RX_AW     = $clog2(RX_DEPTH);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  logic [31:0] address_reg;
  logic [15:0] data_reg;
  logic        r_w_reg;
  logic        request_reg;
  logic        in_range;
  logic        sel;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic [31:0] stat_word;

  logic [15:0] div;
  logic [4:0]  ctrl;
  logic        tx_en, rx_en, loopback, rx_ie, tx_ie;
  logic        rx_ovr, frame_err, tx_ovf;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_AW:0]   tx_level;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_AW:0]   rx_level;
  logic [8:0]       tx_lvl_ext;
  logic [8:0]       rx_lvl_ext;
  logic             unused_bits;

  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_stop_cnt;
  logic        tx_line;
  logic        tx_busy;
  logic        tx_bit_end;

  rx_state_t   rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_src;
  logic        rx_bit_end;
  logic        frame_err_set;

  assign tx_en    = ctrl[CTRL_TX_EN];
  assign rx_en    = ctrl[CTRL_RX_EN];
  assign loopback = ctrl[CTRL_LOOP];
  assign rx_ie    = ctrl[CTRL_RX_IE];
  assign tx_ie    = ctrl[CTRL_TX_IE];

  // Bus front end: one registered copy per cycle, wiped after the accept cycle.
  always_ff @(posedge clk) begin
    if (rst || sel) begin
      address_reg <= '0;
      data_reg    <= '0;
      r_w_reg     <= 1'b0;
      request_reg <= 1'b0;
    end else begin
      address_reg <= address;
      data_reg    <= data[15:0];
      r_w_reg     <= r_w;
      request_reg <= request;
    end
  end

  assign in_range = ({1'b0, address_reg} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, address_reg} <  ({1'b0, BASE_ADDR} + 33'd16));
  assign sel       = request_reg & in_range;
  assign idx       = address_reg[1:0];
  assign ready_out = sel ? 1'b1 : 1'bz;
  assign data      = (sel && !r_w_reg) ? rdata : 32'bz;

  assign tx_push = sel & r_w_reg & (idx == REG_DATA);
  assign rx_pop  = sel & ~r_w_reg & (idx == REG_DATA) & ~rx_empty;

  assign tx_lvl_ext  = 9'(tx_level);
  assign rx_lvl_ext  = 9'(rx_level);
  assign unused_bits = ^{tx_lvl_ext[8], rx_lvl_ext[8]};

  always_comb begin
    stat_word                 = '0;
    stat_word[STAT_TX_BUSY]   = tx_busy;
    stat_word[STAT_TX_FULL]   = tx_full;
    stat_word[STAT_TX_EMPTY]  = tx_empty;
    stat_word[STAT_RX_EMPTY]  = rx_empty;
    stat_word[STAT_RX_FULL]   = rx_full;
    stat_word[STAT_RX_OVR]    = rx_ovr;
    stat_word[STAT_FRAME_ERR] = frame_err;
    stat_word[STAT_TX_OVF]    = tx_ovf;
    stat_word[15:8]           = tx_lvl_ext[7:0];
    stat_word[23:16]          = rx_lvl_ext[7:0];
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_DATA: if (!rx_empty) rdata = {23'b0, 1'b1, rx_head};
      REG_STAT: rdata = stat_word;
      REG_DIV:  rdata = {16'b0, div};
      REG_CTRL: rdata = {27'b0, ctrl};
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= DEFAULT_DIV;
      ctrl <= CTRL_RESET;
    end else if (sel && r_w_reg) begin
      if (idx == REG_DIV)  div  <= clamp_div(data_reg);
      if (idx == REG_CTRL) ctrl <= data_reg[4:0];
    end
  end

  // Sticky flags: a STAT read clears them, but an event in that same cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      if (sel && !r_w_reg && idx == REG_STAT) begin
        rx_ovr    <= 1'b0;
        frame_err <= 1'b0;
        tx_ovf    <= 1'b0;
      end
      if (rx_push && rx_full && !rx_pop) rx_ovr    <= 1'b1;
      if (frame_err_set)                 frame_err <= 1'b1;
      if (tx_push && tx_full && !tx_pop) tx_ovf    <= 1'b1;
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (data_reg[7:0]),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // Transmitter
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit_end = (tx_cnt == 16'd0);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    tx_line      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_en && !tx_empty) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end && tx_stop_cnt == STOP_LAST) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  // The divisor is latched per frame so a mid-frame DIV write waits for the next start.
  always_ff @(posedge clk) begin
    if (tx_state == TX_IDLE) begin
      if (tx_pop) begin
        tx_shift    <= tx_head;
        tx_div      <= div;
        tx_cnt      <= div - 16'd1;
        tx_bit      <= 3'd0;
        tx_stop_cnt <= 1'b0;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= tx_div - 16'd1;
      if (tx_state == TX_DATA) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
      if (tx_state == TX_STOP) tx_stop_cnt <= ~tx_stop_cnt;
    end else begin
      tx_cnt <= tx_cnt - 16'd1;
    end
  end

  assign TxD = loopback ? 1'b1 : tx_line;

  // Receiver
  assign rx_src = loopback ? tx_line : RxD;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_bit_end = (rx_cnt == 16'd0);

  always_comb begin
    rx_state_nxt  = rx_state;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_en && rx_prev && !rx_s2) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_bit_end) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_bit_end && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_state_nxt  = RX_IDLE;
          rx_push       = rx_s2;
          frame_err_set = ~rx_s2;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  // First wait is half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    case (rx_state)
      RX_IDLE: begin
        rx_div <= div;
        rx_cnt <= (div >> 1) - 16'd1;
        rx_bit <= 3'd0;
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          rx_cnt   <= rx_div - 16'd1;
        end else begin
          rx_cnt <= rx_cnt - 16'd1;
        end
      end
      default: begin
        if (rx_bit_end) rx_cnt <= rx_div - 16'd1;
        else            rx_cnt <= rx_cnt - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);
  end

endmodule
